// File: rtl/if_stage_if.sv
// rtl/if_stage_if.sv - fetch-stage bundle: decode handshake, redirect bus and instruction SRAM port
interface if_stage_if;
    logic        id_allow_in;
    logic [32:0] id_to_if_branch_bus;
    logic [64:0] if_to_id_instruction_bus;
    logic        instruction_sram_enabled;
    logic [3:0]  instruction_sram_write_enabled;
    logic [31:0] instruction_sram_address;
    logic [31:0] instruction_sram_write_data;
    logic [31:0] instruction_sram_read_data;

    modport master (
        input  id_allow_in,
        input  id_to_if_branch_bus,
        input  instruction_sram_read_data,
        output if_to_id_instruction_bus,
        output instruction_sram_enabled,
        output instruction_sram_write_enabled,
        output instruction_sram_address,
        output instruction_sram_write_data
    );

    modport slave (
        output id_allow_in,
        output id_to_if_branch_bus,
        output instruction_sram_read_data,
        input  if_to_id_instruction_bus,
        input  instruction_sram_enabled,
        input  instruction_sram_write_enabled,
        input  instruction_sram_address,
        input  instruction_sram_write_data
    );
endinterface

// File: rtl/if_stage.sv
// rtl/if_stage.sv - MIPS instruction-fetch stage with SRAM hold buffer and delay-slot redirect
module if_stage #(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC00000
) (
    input logic        clock,
    input logic        reset,
    if_stage_if.master bus
);
    logic        if_valid_q, if_valid_d;
    logic [31:0] pc_q, pc_d;
    logic        fresh_q, fresh_d;
    logic        hold_valid_q, hold_valid_d;
    logic [31:0] hold_data_q, hold_data_d;
    logic        pend_q, pend_d;
    logic [31:0] pend_target_q, pend_target_d;

    logic        branch_taken;
    logic [31:0] branch_target;
    logic        pre_if_valid;
    logic        if_allow_in;
    logic        if_req;
    logic        transfer;
    logic        delay_slot_issued;
    logic [31:0] next_pc;
    logic [31:0] instruction;

    assign branch_taken      = bus.id_to_if_branch_bus[32];
    assign branch_target     = bus.id_to_if_branch_bus[31:0];
    assign pre_if_valid      = !reset;
    assign if_allow_in       = !if_valid_q || bus.id_allow_in;
    assign if_req            = pre_if_valid && if_allow_in;
    assign transfer          = if_valid_q && bus.id_allow_in;
    // The instruction leaving IF while the branch sits in ID is its delay slot.
    assign delay_slot_issued = transfer;

    always_comb begin
        next_pc = pc_q + 32'd4;
        if (pend_q) begin
            next_pc = pend_target_q;
        end else if (branch_taken && delay_slot_issued) begin
            next_pc = branch_target;
        end
    end

    always_comb begin
        if_valid_d    = if_valid_q;
        pc_d          = pc_q;
        fresh_d       = if_req;
        hold_valid_d  = hold_valid_q;
        hold_data_d   = hold_data_q;
        pend_d        = pend_q;
        pend_target_d = pend_target_q;

        if (if_req) begin
            if_valid_d = 1'b1;
            pc_d       = next_pc;
        end else if (if_allow_in) begin
            if_valid_d = 1'b0;
        end

        // SRAM data lives for one cycle only; park it if decode is not taking it.
        if (transfer) begin
            hold_valid_d = 1'b0;
        end else if (if_valid_q && fresh_q && !hold_valid_q) begin
            hold_valid_d = 1'b1;
            hold_data_d  = bus.instruction_sram_read_data;
        end

        // Branch seen with IF empty: this cycle's request is the delay slot, redirect the one after.
        if (pend_q) begin
            if (if_req) begin
                pend_d = 1'b0;
            end
        end else if (branch_taken && !if_valid_q) begin
            pend_d        = 1'b1;
            pend_target_d = branch_target;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            if_valid_q    <= 1'b0;
            pc_q          <= RESET_VECTOR - 32'd4;
            fresh_q       <= 1'b0;
            hold_valid_q  <= 1'b0;
            hold_data_q   <= 32'd0;
            pend_q        <= 1'b0;
            pend_target_q <= 32'd0;
        end else begin
            if_valid_q    <= if_valid_d;
            pc_q          <= pc_d;
            fresh_q       <= fresh_d;
            hold_valid_q  <= hold_valid_d;
            hold_data_q   <= hold_data_d;
            pend_q        <= pend_d;
            pend_target_q <= pend_target_d;
        end
    end

    assign instruction = hold_valid_q ? hold_data_q : bus.instruction_sram_read_data;

    assign bus.if_to_id_instruction_bus       = {if_valid_q && !reset, pc_q, instruction};
    assign bus.instruction_sram_enabled       = if_req;
    assign bus.instruction_sram_address       = next_pc;
    assign bus.instruction_sram_write_enabled = 4'b0000;
    assign bus.instruction_sram_write_data    = 32'd0;
endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - testbench for if_stage: directed fetch/stall/branch/reset/wrap plus random traffic
module tb_if_stage;
    logic clock;
    logic reset;

    if_stage_if bus ();

    if_stage #(.RESET_VECTOR(32'hBFC00000)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int tests;
    int fails;

    logic [31:0] fetch_q[$];
    logic [31:0] req_log[$];
    logic [31:0] last_req;
    logic        redir_next;
    logic [31:0] redir_tgt;
    logic        id_valid;
    logic        id_branch;
    logic [31:0] id_tgt;
    logic [31:0] br_pc;
    logic [31:0] br_tgt;
    logic        rand_br;

    logic        s_valid;
    logic        s_en;
    logic [31:0] s_addr;
    logic [31:0] s_pc;
    logic [31:0] s_instr;

    function automatic logic [31:0] mem(input logic [31:0] a);
        if (a == 32'hBFC00004) return 32'h24080001;
        return (a * 32'h9E3779B1) ^ 32'h3C1D0000;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        fetch_q.delete();
        last_req   = 32'hBFC00000 - 32'd4;
        redir_next = 1'b0;
        redir_tgt  = 32'd0;
        id_valid   = 1'b0;
        id_branch  = 1'b0;
        id_tgt     = 32'd0;
    endtask

    function automatic int count_in_log(input logic [31:0] a);
        int n = 0;
        foreach (req_log[i]) if (req_log[i] == a) n++;
        return n;
    endfunction

    // One clock: drive inputs, sample and score at negedge, then advance the SRAM model.
    task automatic cycle(input logic allow, input logic rst);
        logic        bt;
        logic        exp_valid;
        logic        exp_req;
        logic        new_br;
        logic [31:0] head;
        logic [31:0] junk;
        logic [31:0] exp_addr;
        logic [31:0] new_tgt;

        bt   = id_valid && id_branch;
        junk = $urandom();
        reset = rst;
        bus.id_allow_in         = allow;
        bus.id_to_if_branch_bus = {bt, bt ? id_tgt : junk};

        @(negedge clock);
        s_valid = bus.if_to_id_instruction_bus[64];
        s_pc    = bus.if_to_id_instruction_bus[63:32];
        s_instr = bus.if_to_id_instruction_bus[31:0];
        s_en    = bus.instruction_sram_enabled;
        s_addr  = bus.instruction_sram_address;
        check("wstrb", {28'd0, bus.instruction_sram_write_enabled}, 32'd0);
        check("wdata", bus.instruction_sram_write_data, 32'd0);

        if (rst) begin
            check("rst_valid", {31'd0, s_valid}, 32'd0);
            check("rst_en", {31'd0, s_en}, 32'd0);
        end else begin
            exp_valid = (fetch_q.size() != 0);
            exp_req   = !exp_valid || allow;
            check("valid", {31'd0, s_valid}, {31'd0, exp_valid});
            if (exp_valid) begin
                check("pc", s_pc, fetch_q[0]);
                check("instr", s_instr, mem(fetch_q[0]));
            end
            check("req", {31'd0, s_en}, {31'd0, exp_req});

            new_br  = 1'b0;
            new_tgt = 32'd0;
            head    = 32'd0;
            if (exp_valid && allow) begin
                head = fetch_q.pop_front();
                if (!id_branch && (head == br_pc || (rand_br && $urandom_range(0, 5) == 0))) begin
                    new_br  = 1'b1;
                    new_tgt = rand_br ? $urandom() : br_tgt;
                    new_tgt[1:0] = 2'b00;
                end
            end

            if (exp_req) begin
                exp_addr = redir_next ? redir_tgt : last_req + 32'd4;
                check("addr", s_addr, exp_addr);
                redir_next = 1'b0;
                last_req   = exp_addr;
                fetch_q.push_back(exp_addr);
                req_log.push_back(exp_addr);
            end

            if (exp_valid && allow) begin
                id_valid  = 1'b1;
                id_branch = new_br;
                id_tgt    = new_tgt;
                if (new_br) begin
                    redir_next = 1'b1;
                    redir_tgt  = new_tgt;
                end
            end else if (allow) begin
                id_valid  = 1'b0;
                id_branch = 1'b0;
            end
        end

        @(posedge clock);
        #1;
        junk = $urandom();
        bus.instruction_sram_read_data = s_en ? mem(s_addr) : junk;
        if (rst) model_reset();
    endtask

    initial begin
        clock = 1'b0;
        reset = 1'b1;
        tests = 0;
        fails = 0;
        bus.id_allow_in                = 1'b0;
        bus.id_to_if_branch_bus        = 33'd0;
        bus.instruction_sram_read_data = 32'd0;
        br_pc   = 32'hFFFFFFFF;
        br_tgt  = 32'd0;
        rand_br = 1'b0;
        model_reset();

        // Reset then sequential fetch and a 4-cycle decode stall
        repeat (3) cycle(1'b1, 1'b1);
        cycle(1'b1, 1'b0);
        check("t1_addr0", s_addr, 32'hBFC00000);
        check("t1_valid0", {31'd0, s_valid}, 32'd0);
        cycle(1'b1, 1'b0);
        check("t1_valid1", {31'd0, s_valid}, 32'd1);
        check("t1_pc1", s_pc, 32'hBFC00000);
        check("t1_addr1", s_addr, 32'hBFC00004);
        repeat (4) begin
            cycle(1'b0, 1'b0);
            check("t2_en", {31'd0, s_en}, 32'd0);
            check("t2_pc", s_pc, 32'hBFC00004);
            check("t2_instr", s_instr, 32'h24080001);
        end
        cycle(1'b1, 1'b0);
        check("t2_addr", s_addr, 32'hBFC00008);
        check("t2_instr_rel", s_instr, 32'h24080001);

        // Taken branch at BFC00010 with delay slot already in IF
        cycle(1'b1, 1'b1);
        req_log.delete();
        br_pc  = 32'hBFC00010;
        br_tgt = 32'hBFC00100;
        repeat (12) cycle(1'b1, 1'b0);
        check("t3_redirect", req_log[6], 32'hBFC00100);
        check("t3_no_018", count_in_log(32'hBFC00018), 32'd0);

        // Same branch, decode stalled for 3 cycles while branch_taken is held
        cycle(1'b1, 1'b1);
        req_log.delete();
        repeat (6) cycle(1'b1, 1'b0);
        repeat (3) begin
            cycle(1'b0, 1'b0);
            check("t4_stall_en", {31'd0, s_en}, 32'd0);
        end
        cycle(1'b1, 1'b0);
        check("t4_redirect", s_addr, 32'hBFC00100);
        repeat (4) cycle(1'b1, 1'b0);
        check("t4_once", count_in_log(32'hBFC00100), 32'd1);
        check("t4_no_018", count_in_log(32'hBFC00018), 32'd0);

        // Reset while the hold buffer is full and a redirect is outstanding
        cycle(1'b1, 1'b1);
        repeat (6) cycle(1'b1, 1'b0);
        repeat (2) cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b1);
        req_log.delete();
        cycle(1'b1, 1'b0);
        check("t5_valid", {31'd0, s_valid}, 32'd0);
        check("t5_addr", s_addr, 32'hBFC00000);

        // 32-bit wraparound of the sequential PC
        cycle(1'b1, 1'b1);
        req_log.delete();
        br_pc  = 32'hBFC00000;
        br_tgt = 32'hFFFFFFF8;
        repeat (6) begin
            cycle(1'b1, 1'b0);
            check("t6_en", {31'd0, s_en}, 32'd1);
        end
        check("t6_a2", req_log[2], 32'hFFFFFFF8);
        check("t6_a3", req_log[3], 32'hFFFFFFFC);
        check("t6_a4", req_log[4], 32'h00000000);

        // Random decode stalls, random branches and occasional resets
        cycle(1'b1, 1'b1);
        br_pc   = 32'hFFFFFFFF;
        rand_br = 1'b1;
        for (int i = 0; i < 800; i++) begin
            cycle($urandom_range(0, 9) < 7, $urandom_range(0, 199) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline.
- Generates the fetch PC and drives the synchronous instruction SRAM (1-cycle read latency).
- Delivers {valid, program_count, instruction} to the decode stage.
- Consumes the decode stage's {branch_taken, branch_target} redirect bus, with one architectural delay slot.

Parameters:
- RESET_VECTOR, 32'hBFC00000, PC of the first instruction fetched after reset.

Ports:
- clock  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-high
- id_allow_in  input  1  decode stage can accept an instruction this cycle
- id_to_if_branch_bus  input  33  id_stage_params::IDToIFBranchBusData; bit 32 = branch_taken, [31:0] = branch_target
- if_to_id_instruction_bus  output  65  if_stage_params::IFToIDInstructionBusData; valid, program_count[31:0], instruction[31:0]
- instruction_sram_enabled  output  1  read request this cycle
- instruction_sram_write_enabled  output  4  byte write strobes, constant 4'b0
- instruction_sram_address  output  32  byte address of the request
- instruction_sram_write_data  output  32  constant 32'b0
- instruction_sram_read_data  input  32  data for the request issued in the previous cycle

Behaviour:
- Reset:
  - if_valid = 0, program_count register = RESET_VECTOR-4, hold_valid = 0, pending_redirect = 0.
  - Outputs during reset: valid = 0, instruction_sram_enabled = 0.
- Pre-IF request:
  - pre_if_valid = !reset (1 from the first cycle after reset deasserts).
  - if_allow_in = !if_valid || (if_ready_go && id_allow_in), with if_ready_go = 1.
  - instruction_sram_enabled = pre_if_valid && if_allow_in; address = next_pc.
- next_pc priority:
  1. pending_redirect ? pending_target
  2. else branch_taken && delay_slot_issued ? branch_target
  3. else program_count + 4, 32-bit wraparound, no overflow check
- IF register: on a request, program_count <= next_pc and if_valid <= 1. If if_allow_in is set but no request, if_valid <= 0.
- Instruction data and hold buffer:
  - SRAM data is valid only in the cycle after the request.
  - If id_allow_in = 0 in that cycle, capture read_data into hold_data and set hold_valid = 1.
  - Output instruction = hold_valid ? hold_data : instruction_sram_read_data.
  - hold_valid clears when the instruction is accepted (if_valid && id_allow_in).
  - hold_data is never overwritten while hold_valid = 1.
- Handshake:
  - Output valid = if_valid; the output is held stable while valid && !id_allow_in.
  - Transfer occurs when valid && id_allow_in.
- Delay slot:
  - A taken branch in ID redirects the fetch after the instruction currently in IF (the delay slot).
  - delay_slot_issued = 1 when IF holds a valid instruction that has been, or is this cycle being, transferred after the branch entered ID.
  - If branch_taken is asserted while IF is empty or the delay slot has not yet been fetched, latch pending_redirect = 1 and pending_target = branch_target.
  - pending_redirect is applied on the first request after the delay slot's request, then cleared.
  - branch_taken held high for several stalled cycles causes exactly one redirect.
- Simultaneous events:
  - A redirect request and an ID stall in the same cycle: no request; redirect state retained.
  - Reset overrides everything; reset mid-stall discards the held instruction and any pending redirect.
- SRAM write strobes are always 0.

Test Plan:
- Reset for 3 cycles, then id_allow_in = 1 continuously -> SRAM addresses 0xBFC00000, 0xBFC00004, 0xBFC00008; valid first high one cycle after the first request; program_count matches each address.
- id_allow_in = 0 for 4 cycles while IF holds PC 0xBFC00004 with read_data 0x24080001 -> output held unchanged, no new request; after release, next address is 0xBFC00008 and instruction stays 0x24080001 until accepted.
- Branch (PC 0xBFC00010) in ID asserts branch_taken, target 0xBFC00100; delay slot 0xBFC00014 is in IF -> next request 0xBFC00100; 0xBFC00018 is never requested.
- Same branch with id_allow_in = 0 for 3 cycles during branch_taken -> the only redirected request is 0xBFC00100, issued exactly once after the stall clears.
- Assert reset while hold_valid = 1 and a redirect is pending -> valid = 0 next cycle; after release, the first request is 0xBFC00000.
- Sequential fetch from PC 0xFFFFFFF8 -> addresses 0xFFFFFFFC, then 0x00000000 (wrap), with no stall glitch.
